// File: rtl/dcache_wt_direct_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RREQ  = 3'd1,
    RDATA = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Address segment (addr[31:29]) that bypasses the cache entirely.
  localparam logic [2:0] UNCACHED_SEG = 3'b101;

  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned DEF_INDEX_BITS = 6;

  // Word-offset bits inside a line.
  function automatic int unsigned offb_f(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  // Tag bits left over from the 30-bit word address.
  function automatic int unsigned tag_bits_f(input int unsigned line_words,
                                             input int unsigned index_bits);
    return 30 - $clog2(line_words) - index_bits;
  endfunction

endpackage

// File: rtl/dcache_wt_direct_if.sv
// CPU-side and memory-side bus of the data cache. The cache uses the slave
// view; the pipeline/memory bridge (or a bench) uses the master view.
interface dcache_wt_direct_if;
  logic        cpu_req;
  logic        cpu_wr;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic [7:0]  mem_rd_len;
  logic        mem_rd_ack;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;

  logic        mem_wr_req;
  logic [31:0] mem_wr_addr;
  logic [3:0]  mem_wr_strb;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ack;

  modport slave (
    input  cpu_req, cpu_wr, cpu_wstrb, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    output mem_rd_req, mem_rd_addr, mem_rd_len,
    input  mem_rd_ack, mem_rd_valid, mem_rd_data,
    output mem_wr_req, mem_wr_addr, mem_wr_strb, mem_wr_data,
    input  mem_wr_ack
  );

  modport master (
    output cpu_req, cpu_wr, cpu_wstrb, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    input  mem_rd_req, mem_rd_addr, mem_rd_len,
    output mem_rd_ack, mem_rd_valid, mem_rd_data,
    input  mem_wr_req, mem_wr_addr, mem_wr_strb, mem_wr_data,
    output mem_wr_ack
  );
endinterface

// File: rtl/dcache_data_array.sv
// Line data storage: one byte lane array per strobe bit, single write port
// with byte enables and an asynchronous (combinational) read port.
module dcache_data_array #(
  parameter  int unsigned LINE_WORDS = 4,
  parameter  int unsigned INDEX_BITS = 6,
  localparam int unsigned OFFB       = $clog2(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] widx_i,
  input  logic [OFFB-1:0]       woff_i,
  input  logic [3:0]            wstrb_i,
  input  logic [31:0]           wdata_i,
  input  logic [INDEX_BITS-1:0] ridx_i,
  input  logic [OFFB-1:0]       roff_i,
  output logic [31:0]           rdata_o
);
  localparam int unsigned DEPTH = (1 << INDEX_BITS) * LINE_WORDS;

  logic [INDEX_BITS+OFFB-1:0] waddr;
  logic [INDEX_BITS+OFFB-1:0] raddr;
  logic [7:0]                 rd_byte [4];

  assign waddr = {widx_i, woff_i};
  assign raddr = {ridx_i, roff_i};

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_q [DEPTH];

    // Byte lane write, gated by its strobe bit.
    always_ff @(posedge clk) begin
      if (we_i && wstrb_i[gi]) lane_q[waddr] <= wdata_i[8*gi +: 8];
    end

    assign rd_byte[gi] = lane_q[raddr];
  end

  assign rdata_o = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};

endmodule

// File: rtl/dcache_wt_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache for the M stage.
// Misses become line bursts, stores become single-word writes; the 0xA..0xB
// segment is uncached (1-beat reads, never allocated).
module dcache_wt_direct
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned INDEX_BITS = DEF_INDEX_BITS
) (
  input logic         clk,
  input logic         rst_n,
  dcache_wt_direct_if.slave bus
);
  localparam int unsigned OFFB      = offb_f(LINE_WORDS);
  localparam int unsigned TAG_BITS  = tag_bits_f(LINE_WORDS, INDEX_BITS);
  localparam int unsigned LINES     = 1 << INDEX_BITS;
  localparam logic [OFFB-1:0] LAST_BEAT = OFFB'(LINE_WORDS - 1);

  state_e                state_q;
  logic [29:0]           lat_addr_q;   // latched word address
  logic                  lat_wr_q;
  logic [3:0]            lat_strb_q;
  logic [31:0]           lat_wdata_q;
  logic [OFFB-1:0]       cnt_q;
  logic [31:0]           hold_q;       // uncached read beat
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q [LINES];

  logic                  mem_rd_req_q;
  logic [31:0]           mem_rd_addr_q;
  logic [7:0]            mem_rd_len_q;
  logic                  mem_wr_req_q;
  logic [31:0]           mem_wr_addr_q;
  logic [3:0]            mem_wr_strb_q;
  logic [31:0]           mem_wr_data_q;

  // Incoming request fields.
  logic [OFFB-1:0]       req_off;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  req_unc;
  logic                  req_hit;

  assign req_off = bus.cpu_addr[2 +: OFFB];
  assign req_idx = bus.cpu_addr[2+OFFB +: INDEX_BITS];
  assign req_tag = bus.cpu_addr[31 -: TAG_BITS];
  assign req_unc = (bus.cpu_addr[31:29] == UNCACHED_SEG);
  assign req_hit = !req_unc && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Latched request fields.
  logic [OFFB-1:0]       lat_off;
  logic [INDEX_BITS-1:0] lat_idx;
  logic [TAG_BITS-1:0]   lat_tag;
  logic                  lat_unc;
  logic                  lat_hit;

  assign lat_off = lat_addr_q[0 +: OFFB];
  assign lat_idx = lat_addr_q[OFFB +: INDEX_BITS];
  assign lat_tag = lat_addr_q[29 -: TAG_BITS];
  assign lat_unc = (lat_addr_q[29:27] == UNCACHED_SEG);
  assign lat_hit = !lat_unc && valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

  logic refill_last;
  assign refill_last = (state_q == RDATA) && bus.mem_rd_valid && !lat_unc &&
                       (cnt_q == LAST_BEAT);

  // Data array port selection: refill beats and store-hit merges share the
  // write port; reads follow the CPU in IDLE and the latched access in RESP.
  logic                  arr_we;
  logic [OFFB-1:0]       arr_woff;
  logic [3:0]            arr_strb;
  logic [31:0]           arr_wdata;
  logic [INDEX_BITS-1:0] arr_ridx;
  logic [OFFB-1:0]       arr_roff;
  logic [31:0]           arr_rdata;

  // Pick the write source for the line array.
  always_comb begin
    arr_we    = 1'b0;
    arr_woff  = lat_off;
    arr_strb  = 4'hF;
    arr_wdata = bus.mem_rd_data;
    if (state_q == RDATA && bus.mem_rd_valid && !lat_unc) begin
      arr_we   = 1'b1;
      arr_woff = cnt_q;
    end else if (state_q == WRITE && bus.mem_wr_ack && lat_hit) begin
      arr_we    = 1'b1;
      arr_strb  = lat_strb_q;
      arr_wdata = lat_wdata_q;
    end
  end

  assign arr_ridx = (state_q == RESP) ? lat_idx : req_idx;
  assign arr_roff = (state_q == RESP) ? lat_off : req_off;

  dcache_data_array #(
    .LINE_WORDS (LINE_WORDS),
    .INDEX_BITS (INDEX_BITS)
  ) u_data (
    .clk     (clk),
    .we_i    (arr_we),
    .widx_i  (lat_idx),
    .woff_i  (arr_woff),
    .wstrb_i (arr_strb),
    .wdata_i (arr_wdata),
    .ridx_i  (arr_ridx),
    .roff_i  (arr_roff),
    .rdata_o (arr_rdata)
  );

  // Tag is written together with the final refill beat.
  always_ff @(posedge clk) begin
    if (refill_last) tag_q[lat_idx] <= lat_tag;
  end

  // CPU response: hits answer in IDLE, everything else answers in RESP.
  always_comb begin
    bus.cpu_stall = 1'b0;
    bus.cpu_rdata = '0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (!bus.cpu_wr && req_hit) bus.cpu_rdata = arr_rdata;
          else                        bus.cpu_stall = 1'b1;
        end
      end
      RESP: begin
        if (!lat_wr_q) bus.cpu_rdata = lat_unc ? hold_q : arr_rdata;
      end
      default: bus.cpu_stall = 1'b1;
    endcase
  end

  // Control FSM with registered memory-side requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      lat_addr_q    <= '0;
      lat_wr_q      <= 1'b0;
      lat_strb_q    <= '0;
      lat_wdata_q   <= '0;
      cnt_q         <= '0;
      hold_q        <= '0;
      valid_q       <= '0;
      mem_rd_req_q  <= 1'b0;
      mem_rd_addr_q <= '0;
      mem_rd_len_q  <= '0;
      mem_wr_req_q  <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_strb_q <= '0;
      mem_wr_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_req && (bus.cpu_wr || !req_hit)) begin
            lat_addr_q  <= bus.cpu_addr[31:2];
            lat_wr_q    <= bus.cpu_wr;
            lat_strb_q  <= bus.cpu_wstrb;
            lat_wdata_q <= bus.cpu_wdata;
            if (bus.cpu_wr) begin
              state_q       <= WRITE;
              mem_wr_req_q  <= 1'b1;
              mem_wr_addr_q <= {bus.cpu_addr[31:2], 2'b00};
              mem_wr_strb_q <= bus.cpu_wstrb;
              mem_wr_data_q <= bus.cpu_wdata;
            end else begin
              state_q      <= RREQ;
              mem_rd_req_q <= 1'b1;
              cnt_q        <= '0;
              if (req_unc) begin
                mem_rd_addr_q <= {bus.cpu_addr[31:2], 2'b00};
                mem_rd_len_q  <= 8'd0;
              end else begin
                mem_rd_addr_q    <= {bus.cpu_addr[31:OFFB+2], {(OFFB+2){1'b0}}};
                mem_rd_len_q     <= 8'(LINE_WORDS - 1);
                valid_q[req_idx] <= 1'b0;
              end
            end
          end
        end
        RREQ: begin
          if (bus.mem_rd_ack) begin
            mem_rd_req_q <= 1'b0;
            state_q      <= RDATA;
          end
        end
        RDATA: begin
          if (bus.mem_rd_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (lat_unc) begin
              hold_q  <= bus.mem_rd_data;
              state_q <= RESP;
            end else if (cnt_q == LAST_BEAT) begin
              valid_q[lat_idx] <= 1'b1;
              state_q          <= RESP;
            end
          end
        end
        WRITE: begin
          if (bus.mem_wr_ack) begin
            mem_wr_req_q <= 1'b0;
            state_q      <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_rd_req  = mem_rd_req_q;
  assign bus.mem_rd_addr = mem_rd_addr_q;
  assign bus.mem_rd_len  = mem_rd_len_q;
  assign bus.mem_wr_req  = mem_wr_req_q;
  assign bus.mem_wr_addr = mem_wr_addr_q;
  assign bus.mem_wr_strb = mem_wr_strb_q;
  assign bus.mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_dcache_wt_direct.sv
// Directed bench for dcache_wt_direct: a word-level memory plus a table of
// resident line addresses predicts hit/miss, memory traffic, stall length and
// load data; a per-cycle monitor checks every delivered load word.
`timescale 1ns/1ps
module tb_dcache_wt_direct;
  localparam int LW = 4;
  localparam int IB = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_wt_direct_if bus_if ();

  dcache_wt_direct #(.LINE_WORDS(LW), .INDEX_BITS(IB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int vectors = 0;
  int errors  = 0;

  logic [31:0] mem_m [logic [31:0]];   // backing memory, word addressed
  logic [31:0] res_m [int];            // resident line base per index

  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem_m.exists(w)) return mem_m[w];
    return w ^ 32'h5EED_0001;
  endfunction

  function automatic bit is_unc(input logic [31:0] a);
    return a[31:29] == 3'b101;
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return (a / (LW * 4)) * (LW * 4);
  endfunction

  function automatic int line_idx(input logic [31:0] a);
    return int'((a / (LW * 4)) % (1 << IB));
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    if (is_unc(a)) return 0;
    if (!res_m.exists(line_idx(a))) return 0;
    return res_m[line_idx(a)] == line_base(a);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Every delivered load word must equal the current memory contents.
  always @(negedge clk) begin
    if (rst_n && bus_if.cpu_req && !bus_if.cpu_wr && !bus_if.cpu_stall)
      check("load_data", bus_if.cpu_rdata, memword(bus_if.cpu_addr));
  end

  // One CPU access with a memory responder; abort_beats >= 0 pulls reset
  // after that many refill beats.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input int ack_dly, input int abort_beats,
                        output logic [31:0] rdata, output int stalls, output logic [31:0] rd_addr);
    bit unc, hit, done, aborted;
    int rd_reqs, wr_reqs, dly, beats_left, beat_i, exp_stalls;
    logic [7:0] rd_len;
    logic [31:0] wr_addr, wr_data, w, cur;
    logic [3:0] wr_strb;
    unc = is_unc(addr); hit = model_hit(addr);
    done = 0; aborted = 0; rd_reqs = 0; wr_reqs = 0; dly = ack_dly;
    beats_left = 0; beat_i = 0; stalls = 0; rdata = '0; rd_addr = '0;
    rd_len = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    @(posedge clk); #1;
    bus_if.cpu_req = 1'b1; bus_if.cpu_wr = wr; bus_if.cpu_addr = addr;
    bus_if.cpu_wstrb = strb; bus_if.cpu_wdata = wdata;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      bus_if.mem_rd_ack = 1'b0; bus_if.mem_rd_valid = 1'b0; bus_if.mem_wr_ack = 1'b0;
      if (!bus_if.cpu_stall) begin
        done = 1; rdata = bus_if.cpu_rdata;
      end else begin
        stalls++;
        if (beats_left > 0) begin
          if (abort_beats >= 0 && beat_i == abort_beats) begin
            rst_n = 1'b0; aborted = 1; done = 1;
          end else begin
            bus_if.mem_rd_valid = 1'b1;
            bus_if.mem_rd_data  = memword(rd_addr + 32'(4 * beat_i));
            beat_i++; beats_left--;
          end
        end else if (bus_if.mem_rd_req && rd_reqs == 0) begin
          if (dly == 0) begin
            bus_if.mem_rd_ack = 1'b1; rd_reqs++;
            rd_addr = bus_if.mem_rd_addr; rd_len = bus_if.mem_rd_len;
            beats_left = int'(rd_len) + 1;
          end else dly--;
        end
        if (bus_if.mem_wr_req && wr_reqs == 0) begin
          if (dly == 0) begin
            bus_if.mem_wr_ack = 1'b1; wr_reqs++;
            wr_addr = bus_if.mem_wr_addr; wr_strb = bus_if.mem_wr_strb; wr_data = bus_if.mem_wr_data;
            w = wr_addr; cur = memword(w);
            for (int b = 0; b < 4; b++) if (wr_strb[b]) cur[8*b +: 8] = wr_data[8*b +: 8];
            mem_m[w] = cur;
          end else dly--;
        end
      end
    end
    check("completed", 32'(done), 32'd1);
    check("rd_req_count", rd_reqs, (!wr && !hit) ? 1 : 0);
    check("wr_req_count", wr_reqs, wr ? 1 : 0);
    if (!wr && !hit) begin
      check("rd_addr", rd_addr, unc ? {addr[31:2], 2'b00} : line_base(addr));
      check("rd_len", 32'(rd_len), unc ? 32'd0 : 32'(LW - 1));
    end
    if (wr) begin
      check("wr_addr", wr_addr, {addr[31:2], 2'b00});
      check("wr_strb", 32'(wr_strb), 32'(strb));
      check("wr_data", wr_data, wdata);
    end
    if (aborted) begin
      bus_if.cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      check("stall_in_reset", 32'(bus_if.cpu_stall), 32'd0);
      check("rd_req_in_reset", 32'(bus_if.mem_rd_req), 32'd0);
      rst_n = 1'b1;
      res_m.delete();
    end else begin
      if (wr)       exp_stalls = 1 + ack_dly + 1;
      else if (hit) exp_stalls = 0;
      else          exp_stalls = 1 + ack_dly + 1 + (unc ? 1 : LW);
      check("stall_cycles", stalls, exp_stalls);
      if (!wr && !hit && !unc) res_m[line_idx(addr)] = line_base(addr);
    end
  endtask

  logic [31:0] rd, ra;
  int st;

  initial begin
    bus_if.cpu_req = 0; bus_if.cpu_wr = 0; bus_if.cpu_wstrb = 0;
    bus_if.cpu_addr = 0; bus_if.cpu_wdata = 0;
    bus_if.mem_rd_ack = 0; bus_if.mem_rd_valid = 0; bus_if.mem_rd_data = 0;
    bus_if.mem_wr_ack = 0;
    mem_m[32'h10] = 32'hA0; mem_m[32'h14] = 32'hA1;
    mem_m[32'h18] = 32'hA2; mem_m[32'h1C] = 32'hA3;

    repeat (3) @(negedge clk);
    check("rst_stall", 32'(bus_if.cpu_stall), 32'd0);
    check("rst_rd_req", 32'(bus_if.mem_rd_req), 32'd0);
    check("rst_wr_req", 32'(bus_if.mem_wr_req), 32'd0);
    check("rst_rdata", bus_if.cpu_rdata, 32'd0);
    rst_n = 1'b1;

    // Cold load then a same-line hit with no bubble.
    access(0, 32'h0000_0010, 4'h0, 32'h0, 0, -1, rd, st, ra);
    check("cold_rdata", rd, 32'h0000_00A0);
    check("cold_stalls", st, 6);
    check("cold_rd_addr", ra, 32'h0000_0010);
    access(0, 32'h0000_001C, 4'h0, 32'h0, 0, -1, rd, st, ra);
    check("hit_rdata", rd, 32'h0000_00A3);
    check("hit_stalls", st, 0);

    // Store hit merges low half.
    access(1, 32'h0000_0014, 4'b0011, 32'hFFFF_1234, 0, -1, rd, st, ra);
    access(0, 32'h0000_0014, 4'h0, 32'h0, 0, -1, rd, st, ra);
    check("merge_rdata", rd, 32'h0000_1234);

    // Store miss does not allocate.
    access(1, 32'h0000_0400, 4'hF, 32'hDEAD_BEEF, 0, -1, rd, st, ra);
    access(0, 32'h0000_0400, 4'h0, 32'h0, 0, -1, rd, st, ra);
    check("nwa_rdata", rd, 32'hDEAD_BEEF);

    // Conflict misses on index 0.
    access(0, 32'h0000_0000, 4'h0, 32'h0, 1, -1, rd, st, ra);
    access(0, 32'h0000_0400, 4'h0, 32'h0, 0, -1, rd, st, ra);
    access(0, 32'h0000_0000, 4'h0, 32'h0, 2, -1, rd, st, ra);

    // Uncached loads always go to memory; uncached store.
    access(0, 32'hA000_0008, 4'h0, 32'h0, 2, -1, rd, st, ra);
    check("unc_rd_addr", ra, 32'hA000_0008);
    access(0, 32'hA000_0008, 4'h0, 32'h0, 0, -1, rd, st, ra);
    check("unc_repeat_stalls", st, 3);
    access(1, 32'hA000_0010, 4'hF, 32'h1357_9BDF, 1, -1, rd, st, ra);

    // Delayed store hit, upper bytes.
    access(1, 32'h0000_0018, 4'b1100, 32'hBEEF_0000, 3, -1, rd, st, ra);
    access(0, 32'h0000_0018, 4'h0, 32'h0, 0, -1, rd, st, ra);
    check("upper_merge_rdata", rd, 32'hBEEF_00A2);

    // Reset after two refill beats, then full refill.
    access(0, 32'h0000_0040, 4'h0, 32'h0, 1, 2, rd, st, ra);
    access(0, 32'h0000_0040, 4'h0, 32'h0, 0, -1, rd, st, ra);
    check("post_reset_stalls", st, 6);
    access(0, 32'h0000_0010, 4'h0, 32'h0, 0, -1, rd, st, ra);
    access(0, 32'h0000_0044, 4'h0, 32'h0, 0, -1, rd, st, ra);

    @(posedge clk); #1;
    bus_if.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
